// File: rtl/peripheral_apb4_initiator.sv
// APB4 initiator: turns valid/ready commands into single APB4 transfers and returns a response.
// Optional ACCESS-phase timeout abort is enabled with PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN.
module peripheral_apb4_initiator #(
  parameter int PADDR_SIZE     = 4,
  parameter int PDATA_SIZE     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [PADDR_SIZE-1:0]   req_addr,
  input  logic [PDATA_SIZE-1:0]   req_wdata,
  input  logic [PDATA_SIZE/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_SIZE = PDATA_SIZE/8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_r;

`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
  // The abort fires on the ACCESS cycle whose increment would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES-1);

  logic [CNT_W-1:0] tmo_cnt_r;
  logic             rsp_timeout_r;

  assign rsp_timeout = rsp_timeout_r;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Transfer sequencer: FSM state plus all registered APB and response outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= {PADDR_SIZE{1'b0}};
      PWRITE    <= 1'b0;
      PWDATA    <= {PDATA_SIZE{1'b0}};
      PSTRB     <= {STRB_SIZE{1'b0}};
      rsp_valid <= 1'b0;
      rsp_rdata <= {PDATA_SIZE{1'b0}};
      rsp_err   <= 1'b0;
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
      tmo_cnt_r     <= {CNT_W{1'b0}};
      rsp_timeout_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            state_r   <= SETUP;
            req_ready <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PADDR     <= req_addr;
            PWRITE    <= req_write;
            PWDATA    <= req_wdata;
            PSTRB     <= req_write ? req_strb : {STRB_SIZE{1'b0}};
          end else begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          state_r <= ACCESS;
          PENABLE <= 1'b1;
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
          tmo_cnt_r <= {CNT_W{1'b0}};
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            state_r   <= RESP;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? {PDATA_SIZE{1'b0}} : PRDATA;
            rsp_err   <= PSLVERR;
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
            rsp_timeout_r <= 1'b0;
`endif
          end
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
          else if (tmo_cnt_r == CNT_LAST) begin
            state_r       <= RESP;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= {PDATA_SIZE{1'b0}};
            rsp_err       <= 1'b1;
            rsp_timeout_r <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
`else
          else begin
            state_r <= ACCESS;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_apb4_initiator.sv
// Directed bench for peripheral_apb4_initiator with a small APB register-file responder.
module tb_peripheral_apb4_initiator;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic [0:0] req_strb;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err, rsp_timeout;
  logic       PSEL, PENABLE, PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA;
  logic [0:0] PSTRB;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  peripheral_apb4_initiator dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Responder: 16-byte register file, programmable wait states and error.
  logic [7:0] mem [16];
  int         wait_cycles;
  logic       err_flag;
  int         acc_cnt;

  function automatic logic [7:0] init_val(input int i);
    if (i == 8) return 8'h3C;
    else if (i == 2) return 8'h77;
    else return 8'(i * 17);
  endfunction

  assign PREADY  = (acc_cnt >= wait_cycles);
  assign PRDATA  = (PSEL && !PWRITE) ? mem[PADDR] : 8'h00;
  assign PSLVERR = err_flag && PSEL && PENABLE && PREADY;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      acc_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE && PSTRB[0]) mem[PADDR] <= PWDATA;
    end
  end

  // Bus monitor: cumulative counts of select/enable cycles and of unstable bus fields.
  logic [3:0] exp_addr;
  logic       exp_write;
  logic [7:0] exp_wdata;
  logic [0:0] exp_strb;
  int psel_cnt = 0, pen_cnt = 0, bus_bad = 0;

  always @(negedge PCLK) begin
    if (PSEL) psel_cnt <= psel_cnt + 1;
    if (PENABLE) pen_cnt <= pen_cnt + 1;
    if (PSEL && (PADDR !== exp_addr || PWRITE !== exp_write ||
                 PWDATA !== exp_wdata || PSTRB !== exp_strb))
      bus_bad <= bus_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int lat, d_psel, d_pen, d_bad;

  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d,
                       input logic s, input bit scramble);
    int n, p0, e0, b0;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
    exp_addr = a; exp_write = w; exp_wdata = d; exp_strb = w ? s : 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk("req_ready_at_issue", req_ready, 1);
    p0 = psel_cnt; e0 = pen_cnt; b0 = bus_bad;
    @(posedge PCLK);
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
      if (scramble) begin
        req_valid = 1'($urandom); req_write = 1'($urandom);
        req_addr = 4'($urandom); req_wdata = 8'($urandom); req_strb = 1'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end while (!rsp_valid && lat < 100);
    req_valid = 1'b0;
    chk("rsp_valid_seen", rsp_valid, 1);
    d_psel = psel_cnt - p0; d_pen = pen_cnt - e0; d_bad = bus_bad - b0;
  endtask

  task automatic finish_rsp();
    @(negedge PCLK);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", rsp_valid, 0);
    chk("req_ready_restored", req_ready, 1);
  endtask

  initial begin
    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0;
    req_wdata = 8'h00; req_strb = 1'b0; rsp_ready = 1'b0;
    wait_cycles = 0; err_flag = 1'b0;
    exp_addr = 4'h0; exp_write = 1'b0; exp_wdata = 8'h00; exp_strb = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);
    PRESETn = 1'b1;

    // Zero-wait write
    issue(1'b1, 4'h4, 8'hA5, 1'b1, 1'b0);
    chk("wr_latency", lat, 3);
    chk("wr_psel_cycles", d_psel, 2);
    chk("wr_penable_cycles", d_pen, 1);
    chk("wr_bus_stable", d_bad, 0);
    chk("wr_pwrite_hold", PWRITE, 1);
    chk("wr_pwdata_hold", PWDATA, 8'hA5);
    chk("wr_pstrb_hold", PSTRB, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_timeout", rsp_timeout, 0);
    finish_rsp();

    // Read with three wait states
    wait_cycles = 3;
    issue(1'b0, 4'h8, 8'h99, 1'b1, 1'b0);
    chk("rd_latency", lat, 6);
    chk("rd_psel_cycles", d_psel, 5);
    chk("rd_penable_cycles", d_pen, 4);
    chk("rd_bus_stable", d_bad, 0);
    chk("rd_paddr_hold", PADDR, 4'h8);
    chk("rd_pstrb_zero", PSTRB, 0);
    chk("rd_rsp_rdata", rsp_rdata, 8'h3C);
    chk("rd_rsp_err", rsp_err, 0);
    finish_rsp();

    // Read with PSLVERR, response held while rsp_ready is low
    wait_cycles = 0; err_flag = 1'b1;
    issue(1'b0, 4'h2, 8'h00, 1'b0, 1'b0);
    err_flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_err", rsp_err, 1);
      chk("hold_rsp_rdata", rsp_rdata, 8'h77);
      chk("hold_req_ready", req_ready, 0);
      @(negedge PCLK);
    end
    finish_rsp();

    // Direction register write then read back, with req_* scrambled mid-transfer
    issue(1'b1, 4'h1, 8'hFF, 1'b1, 1'b1);
    chk("gpio_wr_bus_stable", d_bad, 0);
    chk("gpio_wr_psel_cycles", d_psel, 2);
    finish_rsp();
    issue(1'b0, 4'h1, 8'h00, 1'b0, 1'b1);
    chk("gpio_rd_bus_stable", d_bad, 0);
    chk("gpio_rd_rdata", rsp_rdata, 8'hFF);
    finish_rsp();

    // Write with strobe clear leaves the register untouched
    issue(1'b1, 4'h3, 8'h5A, 1'b0, 1'b0);
    chk("nostrb_pstrb", PSTRB, 0);
    finish_rsp();
    issue(1'b0, 4'h3, 8'h00, 1'b0, 1'b0);
    chk("nostrb_readback", rsp_rdata, 8'h33);
    finish_rsp();

    // Reset pulse during ACCESS
    wait_cycles = 10;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h5;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_in_access", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    wait_cycles = 0;
    issue(1'b0, 4'h5, 8'h00, 1'b0, 1'b0);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_rdata", rsp_rdata, 8'h55);
    chk("post_rst_err", rsp_err, 0);
    finish_rsp();

`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
    // Abort after 16 ACCESS cycles with PREADY low
    wait_cycles = 100;
    issue(1'b0, 4'h4, 8'h00, 1'b0, 1'b0);
    chk("tmo_latency", lat, 18);
    chk("tmo_penable_cycles", d_pen, 16);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_timeout", rsp_timeout, 1);
    chk("tmo_rsp_rdata", rsp_rdata, 0);
    finish_rsp();
    // PREADY on the 16th ACCESS cycle wins over the abort
    wait_cycles = 15;
    issue(1'b0, 4'h4, 8'h00, 1'b0, 1'b0);
    chk("tmo_edge_latency", lat, 18);
    chk("tmo_edge_timeout", rsp_timeout, 0);
    chk("tmo_edge_err", rsp_err, 0);
    chk("tmo_edge_rdata", rsp_rdata, 8'h44);
    finish_rsp();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_apb4_initiator.md
Name: peripheral_apb4_initiator

Overview:
- Synthesizable APB4 initiator: the requester-side counterpart of the peripheral_*_apb4 responders such as peripheral_gpio_apb4.
- Converts a simple valid/ready command channel into single APB4 transfers and returns read data and error status on a valid/ready response channel.
- Lets on-chip logic (sequencers, debug, self-test) drive GPIO and other APB4 peripherals without the simulation-only BFM.

Parameters:
- PADDR_SIZE, 4, APB address width
- PDATA_SIZE, 8, APB data width; must be a multiple of 8
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort (used only with the optional feature); must be at least 1

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  PADDR_SIZE  target address
- req_wdata  in  PDATA_SIZE  write data
- req_strb  in  PDATA_SIZE/8  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  PDATA_SIZE  read data (0 for writes)
- rsp_err  out  1  PSLVERR seen, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  PADDR_SIZE  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  PDATA_SIZE  APB write data
- PSTRB  out  PDATA_SIZE/8  APB strobes
- PRDATA  in  PDATA_SIZE  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Interface: one clock (PCLK); reset PRESETn is asynchronous, active-low.
- Reset values:
  - FSM goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB = 0.
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0.
  - req_ready = 1 once in IDLE.
- FSM states IDLE, SETUP, ACCESS, RESP:
  - IDLE: req_ready=1. On req_valid: register addr/write/wdata/strb and go to SETUP. No other state accepts commands.
  - SETUP (1 cycle): PSEL=1, PENABLE=0, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0.
  - ACCESS completion, on PREADY=1:
    - rsp_rdata <= PRDATA for reads, 0 for writes.
    - rsp_err <= PSLVERR.
    - rsp_timeout <= 0.
    - Go to RESP.
    - PSEL and PENABLE drop to 0 in the same cycle that RESP is entered.
  - RESP: rsp_valid=1 with rsp_rdata/rsp_err/rsp_timeout held stable until rsp_ready=1, then go to IDLE and clear rsp_valid.
- Timing:
  - Minimum command-to-rsp_valid latency: 3 cycles (accept, SETUP, ACCESS with PREADY=1).
  - Minimum transfer period: 4 cycles.
- APB4 rules:
  - PADDR, PWRITE, PWDATA, PSTRB stay constant from SETUP through the completing ACCESS cycle and hold their value after it.
  - PSTRB is forced to 0 for reads.
  - PSLVERR and PRDATA are sampled only in ACCESS with PREADY=1.
- rsp_ready high outside RESP is ignored.
- req_* inputs are don't-care outside IDLE. Changing them mid-transfer must not change the bus.
- Reset asserted mid-transfer: bus is released immediately and asynchronously, and any pending response is lost.

Optional Feature:
- Macro: PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer is aborted: PSEL/PENABLE drop, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the abort cycle completes normally (PREADY has priority).
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout is tied to 0.

Test Plan:
- Write 0xA5 to addr 0x4, strb 1, PREADY tied 1 -> PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE=1, PWDATA=0xA5, PSTRB=1; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read addr 0x8, PRDATA=0x3C, PREADY low for 3 ACCESS cycles -> PADDR stable 0x8 and PSTRB=0 throughout; rsp_rdata=0x3C, rsp_err=0.
- Read with PSLVERR=1 on the completing cycle -> rsp_err=1; rsp_valid held 5 cycles while rsp_ready=0, with data stable; req_ready=0 until rsp_ready pulses.
- Back-to-back write/read to peripheral_gpio_apb4 (write 0xFF to the direction register, read it back) -> read returns 0xFF; req_* toggled randomly during the transfer causes no bus change.
- PRESETn pulsed low during ACCESS -> PSEL/PENABLE/rsp_valid = 0 immediately; next command runs normally.
- Macro defined, TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; PREADY=1 on cycle 16 -> normal completion, rsp_timeout=0.
